inflight_tag_tracker: RTL and testbench

- 32-slot in-flight tag allocator and tracker for the OoO core's memory/issue path.
- Hands out the lowest free 5-bit tag on request and retires tags on completion.
- Exposes the registered 32-bit pending vector that feeds the downstream 32-input OR reduction, which produces the "any in flight" drain/fence signal.
- Also provides full/empty status and a sticky protocol-error flag.

---
 rtl/inflight_tag_tracker.sv | 113 +++++++++++
 tb/tb_inflight_tag_tracker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inflight_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module   : inflight_tag_tracker
// Purpose  : 32-slot in-flight tag allocator/tracker. Grants the lowest free
//            tag on request, retires tags on release, clears everything on
//            flush, and exports the registered pending vector that feeds the
//            downstream "any in flight" OR reduction.
// Ports    : clk, rst (async, active-high)
//            alloc_valid (in)  / alloc_ready, alloc_tag (out) : grant channel
//            rel_valid, rel_tag (in)                          : release channel
//            flush (in)                                       : free all tags
//            pending[31:0], full, empty, err (out)            : status
//            occ_count[5:0] (out, only with the macro below)  : occupancy
// Option   : INFLIGHT_TAG_TRACKER_OCC_COUNT_EN adds the registered occupancy
//            counter port occ_count.
// Revision : 1.0 - initial release
// ============================================================================
module inflight_tag_tracker #(
  parameter int NUM_TAGS = 32,
  parameter int TAG_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  output logic [TAG_W-1:0]    alloc_tag,
  input  logic                rel_valid,
  input  logic [TAG_W-1:0]    rel_tag,
  input  logic                flush,
  output logic [NUM_TAGS-1:0] pending,
  output logic                full,
  output logic                empty,
  output logic                err
`ifdef INFLIGHT_TAG_TRACKER_OCC_COUNT_EN
  ,
  output logic [TAG_W:0]      occ_count
`endif
);

  logic [NUM_TAGS-1:0] pending_q, pending_d;
  logic                err_q, err_d;
  logic [TAG_W-1:0]    free_tag;
  logic                alloc_fire;
  logic                rel_hit;

  // Lowest-numbered free slot of the pre-update vector. Scanning downward lets
  // the last assignment win, leaving the smallest index; stays 0 when full.
  always_comb begin
    free_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!pending_q[i]) free_tag = TAG_W'(i);
    end
  end

  // Gating with rst keeps the grant channel closed while reset is held.
  assign alloc_ready = !full && !flush && !rst;
  assign alloc_tag   = free_tag;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign rel_hit     = rel_valid && pending_q[rel_tag];

  // Allocation and release act on different bits: the granted tag is a 0 bit
  // of the pre-update vector, while a successful release targets a 1 bit.
  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (alloc_fire) pending_d[free_tag] = 1'b1;
      if (rel_hit)    pending_d[rel_tag]  = 1'b0;
      if (rel_valid && !pending_q[rel_tag]) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign pending = pending_q;
  assign full    = &pending_q;
  assign empty   = ~|pending_q;
  assign err     = err_q;

`ifdef INFLIGHT_TAG_TRACKER_OCC_COUNT_EN
  logic [TAG_W:0] occ_count_q, occ_count_d;

  // Tracks popcount(pending): a grant and a release in one cycle cancel out.
  always_comb begin
    occ_count_d = occ_count_q;
    if (flush) begin
      occ_count_d = '0;
    end else begin
      occ_count_d = occ_count_q + {{TAG_W{1'b0}}, alloc_fire}
                                - {{TAG_W{1'b0}}, rel_hit};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_count_q <= '0;
    else     occ_count_q <= occ_count_d;
  end

  assign occ_count = occ_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inflight_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_inflight_tag_tracker
// Purpose  : Self-checking bench for inflight_tag_tracker. A set-of-tags model
//            predicts every output each cycle; directed scenarios pin the
//            model with literal values, then randomized traffic follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inflight_tag_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [4:0]  alloc_tag;
  logic        rel_valid = 1'b0;
  logic [4:0]  rel_tag = '0;
  logic        flush = 1'b0;
  logic [31:0] pending;
  logic        full, empty, err;
`ifdef INFLIGHT_TAG_TRACKER_OCC_COUNT_EN
  logic [5:0]  occ_count;
`endif

  inflight_tag_tracker dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .rel_valid   (rel_valid),
    .rel_tag     (rel_tag),
    .flush       (flush),
    .pending     (pending),
    .full        (full),
    .empty       (empty),
    .err         (err)
`ifdef INFLIGHT_TAG_TRACKER_OCC_COUNT_EN
    ,
    .occ_count   (occ_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a set of in-flight tags -------------
  bit in_flight[32];
  bit m_err;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += in_flight[i];
    return n;
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < 32; i++) if (!in_flight[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = in_flight[i];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) in_flight[i] = 0;
      m_err = 0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) in_flight[i] = 0;
    end else begin
      int  t;
      bit  grant;
      bit  was;
      t     = m_lowest_free();
      grant = alloc_valid && (m_count() != 32);
      was   = in_flight[rel_tag];
      if (grant) in_flight[t] = 1;
      if (rel_valid) begin
        if (was) in_flight[rel_tag] = 0;
        else     m_err = 1;
      end
    end
  end

  // ---------------- per-cycle compare against the model --------------------
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_rst", {31'b0, alloc_ready}, 32'd0);
      chk("pending_in_rst", pending, 32'd0);
    end else begin
      bit exp_ready;
      exp_ready = (m_count() != 32) && !flush;
      chk("alloc_ready", {31'b0, alloc_ready}, {31'b0, exp_ready});
      if (exp_ready) chk("alloc_tag", {27'b0, alloc_tag}, m_lowest_free());
      chk("pending", pending, m_vec());
      chk("full",  {31'b0, full},  {31'b0, m_count() == 32});
      chk("empty", {31'b0, empty}, {31'b0, m_count() == 0});
      chk("err",   {31'b0, err},   {31'b0, m_err});
`ifdef INFLIGHT_TAG_TRACKER_OCC_COUNT_EN
      chk("occ_count", {26'b0, occ_count}, m_count());
`endif
    end
  end

  // ---------------- stimulus ----------------------------------------------
  // Inputs change at posedge+1; drive() applies them for one full cycle.
  task automatic drive(input bit av, input bit rv, input logic [4:0] rt, input bit fl);
    alloc_valid = av; rel_valid = rv; rel_tag = rt; flush = fl;
    @(posedge clk); #1;
    alloc_valid = 0; rel_valid = 0; flush = 0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", pending, 32'h0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_ready", {31'b0, alloc_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, alloc_ready}, 32'd1);

    // Fill all 32 tags back to back; grants must come out in order.
    for (int i = 0; i < 32; i++) begin
      alloc_valid = 1;
      #1;
      chk("fill_tag", {27'b0, alloc_tag}, i);
      @(posedge clk); #1;
    end
    alloc_valid = 0;
    chk("full_pending", pending, 32'hFFFF_FFFF);
    chk("full_flag", {31'b0, full}, 32'd1);
    chk("full_ready", {31'b0, alloc_ready}, 32'd0);
    chk("full_empty", {31'b0, empty}, 32'd0);

    // Requester holds alloc_valid while full: nothing may change.
    repeat (3) drive(1, 0, 0, 0);
    chk("hold_full", pending, 32'hFFFF_FFFF);

    // Release tag 7 from full, then re-grant it.
    drive(0, 1, 5'd7, 0);
    chk("rel7_pending", pending, 32'hFFFF_FF7F);
    chk("rel7_ready", {31'b0, alloc_ready}, 32'd1);
    chk("rel7_tag", {27'b0, alloc_tag}, 32'd7);
    drive(1, 0, 0, 0);
    chk("refull", {31'b0, full}, 32'd1);

    // Same-cycle alloc + release of tag 0 with pending = 3.
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("p3", pending, 32'h0000_0003);
    alloc_valid = 1; rel_valid = 1; rel_tag = 5'd0;
    #1;
    chk("simul_tag", {27'b0, alloc_tag}, 32'd2);
    @(posedge clk); #1;
    alloc_valid = 0; rel_valid = 0;
    chk("simul_pending", pending, 32'h0000_0006);

    // Bad release of tag 9: sticky err, state unchanged.
    drive(0, 1, 5'd9, 0);
    chk("bad_rel_pending", pending, 32'h0000_0006);
    chk("bad_rel_err", {31'b0, err}, 32'd1);
    drive(1, 0, 0, 0);
    drive(0, 1, 5'd1, 0);
    chk("err_sticky", {31'b0, err}, 32'd1);

    // Reset, build 0x00F000FF, then flush with concurrent alloc + release.
    rst = 1; @(posedge clk); #1; rst = 0;
    for (int i = 0; i < 24; i++) drive(1, 0, 0, 0);
    for (int i = 8; i < 20; i++) drive(0, 1, 5'(i), 0);
    chk("pre_flush", pending, 32'h00F0_00FF);
    alloc_valid = 1; rel_valid = 1; rel_tag = 5'd3; flush = 1;
    #1;
    chk("flush_ready", {31'b0, alloc_ready}, 32'd0);
    @(posedge clk); #1;
    alloc_valid = 0; rel_valid = 0; flush = 0;
    chk("flush_pending", pending, 32'h0);
    chk("flush_empty", {31'b0, empty}, 32'd1);
    chk("flush_err", {31'b0, err}, 32'd0);
`ifdef INFLIGHT_TAG_TRACKER_OCC_COUNT_EN
    chk("flush_occ", {26'b0, occ_count}, 32'd0);
`endif

    // Asynchronous reset between edges.
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 5'd20, 0);
    #2;
    rst = 1;
    #1;
    chk("async_pending", pending, 32'h0);
    chk("async_empty", {31'b0, empty}, 32'd1);
    chk("async_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // Randomized traffic checked every cycle by the compare process.
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        rst = 1; @(posedge clk); #1; rst = 0;
      end else begin
        logic [4:0] t;
        bit av, rv, fl;
        av = ($urandom_range(0, 99) < 60);
        rv = ($urandom_range(0, 99) < 45);
        fl = ($urandom_range(0, 99) < 2);
        t  = 5'($urandom_range(0, 31));
        // Mostly release a tag that is in flight so the vector drains too.
        if ($urandom_range(0, 9) < 8) begin
          for (int k = 0; k < 32; k++) begin
            if (in_flight[5'(t + 5'(k))]) begin
              t = 5'(t + 5'(k));
              break;
            end
          end
        end
        drive(av, rv, t, fl);
      end
    end

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
